// File: rtl/traffic_phase_ctrl.sv
// Two-road (highway / country road) traffic phase sequencer timed in external tick pulses.
// Define PED_CROSS_EN to add the pedestrian request input (ped_req) and the walk lamp output.
module traffic_phase_ctrl #(
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       sensor,
`ifdef PED_CROSS_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic [1:0] hw_light,
  output logic [1:0] cr_light,
  output logic [2:0] state,
  output logic       phase_chg
);

  localparam logic [2:0] HW_GREEN  = 3'd0;
  localparam logic [2:0] HW_YELLOW = 3'd1;
  localparam logic [2:0] ALLRED_A  = 3'd2;
  localparam logic [2:0] CR_GREEN  = 3'd3;
  localparam logic [2:0] CR_YELLOW = 3'd4;
  localparam logic [2:0] ALLRED_B  = 3'd5;

  localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] T_YEL  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] T_SAT  = '1;

  logic [CNT_W-1:0] timer;
  logic             req;
  logic [2:0]       next_state;
  logic             req_src;
  logic             walk_hold;
  logic             req_window;
  logic             cr_entry;

  // Lamp pair {hw, cr} for a state; illegal codes show the reset lamps.
  function automatic logic [3:0] lamps(input logic [2:0] s);
    case (s)
      HW_GREEN:  lamps = 4'b10_00;
      HW_YELLOW: lamps = 4'b01_00;
      CR_GREEN:  lamps = 4'b00_10;
      CR_YELLOW: lamps = 4'b00_01;
      ALLRED_A,
      ALLRED_B:  lamps = 4'b00_00;
      default:   lamps = 4'b10_00;
    endcase
  endfunction

`ifdef PED_CROSS_EN
  logic ped_lat;
  assign req_src   = sensor | ped_req;
  assign walk_hold = walk;
`else
  assign req_src   = sensor;
  assign walk_hold = 1'b0;
`endif

  assign req_window = (state == HW_GREEN) || (state == HW_YELLOW) ||
                      (state == ALLRED_A) || (state == ALLRED_B);
  assign cr_entry   = (next_state == CR_GREEN) && (state != CR_GREEN);

  always_comb begin
    next_state = state;
    case (state)
      HW_GREEN:  if (tick && (timer >= T_GMIN) && (req || req_src)) next_state = HW_YELLOW;
      HW_YELLOW: if (tick && (timer == T_YEL)) next_state = ALLRED_A;
      ALLRED_A:  if (tick && (timer == T_AR))  next_state = CR_GREEN;
      // A lit walk lamp keeps CR green until the GREEN_MAX cap.
      CR_GREEN:  if (tick && (((timer >= T_GMIN) && !sensor && !walk_hold) || (timer == T_GMAX)))
                   next_state = CR_YELLOW;
      CR_YELLOW: if (tick && (timer == T_YEL)) next_state = ALLRED_B;
      ALLRED_B:  if (tick && (timer == T_AR))  next_state = HW_GREEN;
      default:   next_state = HW_GREEN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HW_GREEN;
      timer     <= '0;
      req       <= 1'b0;
      phase_chg <= 1'b0;
      hw_light  <= 2'b10;
      cr_light  <= 2'b00;
    end else begin
      state                <= next_state;
      phase_chg            <= (next_state != state);
      {hw_light, cr_light} <= lamps(next_state);
      if (next_state != state)
        timer <= '0;
      else if (tick && (timer != T_SAT))
        timer <= timer + 1'b1;
      // Clearing on CR_GREEN entry wins over a same-cycle request.
      if (cr_entry)
        req <= 1'b0;
      else if (req_src && req_window)
        req <= 1'b1;
    end
  end

`ifdef PED_CROSS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_lat <= 1'b0;
      walk    <= 1'b0;
    end else begin
      if (cr_entry)
        ped_lat <= 1'b0;
      else if (ped_req && req_window)
        ped_lat <= 1'b1;
      if (cr_entry)
        walk <= ped_lat;
      else if (next_state != CR_GREEN)
        walk <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed scoreboard bench for traffic_phase_ctrl: expected per-cycle state/lamps/phase_chg
// are queued from the phase-duration plan and compared at each falling clock edge.
module tb_traffic_phase_ctrl;

  localparam logic [2:0] HWG = 3'd0, HWY = 3'd1, ARA = 3'd2, CRG = 3'd3, CRY = 3'd4, ARB = 3'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       sensor = 1'b0;
  logic [1:0] hw_light, cr_light;
  logic [2:0] state;
  logic       phase_chg;
  logic       walk_obs;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] hw;
    logic [1:0] cr;
    logic       pc;
    logic       wk;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

`ifdef PED_CROSS_EN
  logic ped_req = 1'b0;
  logic walk;
  assign walk_obs = walk;
  traffic_phase_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .sensor(sensor),
    .ped_req(ped_req), .walk(walk),
    .hw_light(hw_light), .cr_light(cr_light), .state(state), .phase_chg(phase_chg)
  );
`else
  assign walk_obs = 1'b0;
  traffic_phase_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .sensor(sensor),
    .hw_light(hw_light), .cr_light(cr_light), .state(state), .phase_chg(phase_chg)
  );
`endif

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] st, input logic pc, input logic wk);
    exp_t e;
    e.st = st;
    e.pc = pc;
    e.wk = wk;
    case (st)
      HWG:     {e.hw, e.cr} = 4'b10_00;
      HWY:     {e.hw, e.cr} = 4'b01_00;
      CRG:     {e.hw, e.cr} = 4'b00_10;
      CRY:     {e.hw, e.cr} = 4'b00_01;
      default: {e.hw, e.cr} = 4'b00_00;
    endcase
    return e;
  endfunction

  task automatic push_seg(input logic [2:0] st, input int n, input logic first_pc, input logic wk);
    for (int i = 0; i < n; i++) q.push_back(mk(st, (i == 0) ? first_pc : 1'b0, wk));
  endtask

  task automatic check(input string tag);
    exp_t e;
    exp_t obs;
    obs = {state, hw_light, cr_light, phase_chg, walk_obs};
    total++;
    if (q.size() == 0) begin
      bad++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = q.pop_front();
      assert (obs === e)
      else begin
        bad++;
        $error("FAIL %s: observed st=%0d hw=%b cr=%b pc=%b walk=%b, expected st=%0d hw=%b cr=%b pc=%b walk=%b",
               tag, obs.st, obs.hw, obs.cr, obs.pc, obs.wk, e.st, e.hw, e.cr, e.pc, e.wk);
      end
    end
  endtask

  // Drive the inputs for the current cycle, compare, then advance to the next cycle start.
  task automatic step(input logic t, input logic s, input logic p, input string tag);
    tick   = t;
    sensor = s;
`ifdef PED_CROSS_EN
    ped_req = p;
`else
    if (p) tick = t;
`endif
    check(tag);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset  = 1'b1;
    tick   = 1'b0;
    sensor = 1'b0;
`ifdef PED_CROSS_EN
    ped_req = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    q.push_back(mk(HWG, 1'b0, 1'b0));
    check(tag);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);

    // Idle: no requests, highway stays green.
    do_reset("rst_idle");
    push_seg(HWG, 40, 1'b0, 1'b0);
    for (int c = 0; c < 40; c++) step(1'b1, 1'b0, 1'b0, "idle");

    // Sensor held: full cycle with the CR green cap.
    do_reset("rst_held");
    push_seg(HWG, 4, 1'b0, 1'b0);
    push_seg(HWY, 2, 1'b1, 1'b0);
    push_seg(ARA, 1, 1'b1, 1'b0);
    push_seg(CRG, 8, 1'b1, 1'b0);
    push_seg(CRY, 2, 1'b1, 1'b0);
    push_seg(ARB, 1, 1'b1, 1'b0);
    push_seg(HWG, 1, 1'b1, 1'b0);
    for (int c = 0; c < 19; c++) step(1'b1, 1'b1, 1'b0, "held");

    // Short pulse latched; second pulse on the CR_GREEN entry cycle must not re-arm req.
    do_reset("rst_pulse");
    push_seg(HWG, 4, 1'b0, 1'b0);
    push_seg(HWY, 2, 1'b1, 1'b0);
    push_seg(ARA, 1, 1'b1, 1'b0);
    push_seg(CRG, 4, 1'b1, 1'b0);
    push_seg(CRY, 2, 1'b1, 1'b0);
    push_seg(ARB, 1, 1'b1, 1'b0);
    push_seg(HWG, 8, 1'b1, 1'b0);
    for (int c = 0; c < 22; c++) step(1'b1, (c == 1) || (c == 6), 1'b0, "pulse");

    // Tick every third clock: every phase lasts three times as many clocks.
    do_reset("rst_div3");
    push_seg(HWG, 12, 1'b0, 1'b0);
    push_seg(HWY, 6, 1'b1, 1'b0);
    push_seg(ARA, 3, 1'b1, 1'b0);
    push_seg(CRG, 24, 1'b1, 1'b0);
    push_seg(CRY, 6, 1'b1, 1'b0);
    push_seg(ARB, 3, 1'b1, 1'b0);
    push_seg(HWG, 3, 1'b1, 1'b0);
    for (int c = 0; c < 57; c++) step((c % 3) == 2, 1'b1, 1'b0, "div3");

    // Asynchronous reset in the middle of CR_GREEN.
    do_reset("rst_mid");
    push_seg(HWG, 4, 1'b0, 1'b0);
    push_seg(HWY, 2, 1'b1, 1'b0);
    push_seg(ARA, 1, 1'b1, 1'b0);
    push_seg(CRG, 2, 1'b1, 1'b0);
    for (int c = 0; c < 9; c++) step(1'b1, 1'b1, 1'b0, "mid_pre");
    #2 reset = 1'b1;
    #1 q.push_back(mk(HWG, 1'b0, 1'b0));
    check("async_rst");
    @(negedge clk);
    reset = 1'b0;
    push_seg(HWG, 4, 1'b0, 1'b0);
    push_seg(HWY, 1, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) step(1'b1, 1'b1, 1'b0, "mid_post");

`ifdef PED_CROSS_EN
    // Pedestrian request: walk lamp with full-length CR green.
    do_reset("rst_ped");
    push_seg(HWG, 4, 1'b0, 1'b0);
    push_seg(HWY, 2, 1'b1, 1'b0);
    push_seg(ARA, 1, 1'b1, 1'b0);
    push_seg(CRG, 8, 1'b1, 1'b1);
    push_seg(CRY, 2, 1'b1, 1'b0);
    push_seg(ARB, 1, 1'b1, 1'b0);
    push_seg(HWG, 2, 1'b1, 1'b0);
    for (int c = 0; c < 20; c++) step(1'b1, 1'b0, (c == 2), "ped");
`endif

    total++;
    assert (q.size() == 0)
    else begin
      bad++;
      $error("FAIL leftover: observed %0d queued entries, expected 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Parametrised two-road traffic signal controller for a highway (HW) and a side/country road (CR). It generalises the two-output sensor controller into a timed six-state phase sequencer with green, yellow and all-red intervals. It also adds a latched vehicle request and min/max green limits. All timing counts pulses of an external tick timebase, so one RTL serves any clock rate.

Parameters:
CNT_W, 8, width of the phase timer; must hold max(GREEN_MAX, YELLOW_T, ALLRED_T)
GREEN_MIN, 4, minimum green duration in ticks for either road (>=1)
GREEN_MAX, 8, maximum CR green duration in ticks (>=GREEN_MIN)
YELLOW_T, 2, yellow duration in ticks (>=1)
ALLRED_T, 1, all-red clearance duration in ticks (>=1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
tick  input  1  timebase enable; timer advances only on cycles with tick=1
sensor  input  1  CR vehicle present; synchronous to clk
hw_light  output  2  HW lamp: 2'b00 red, 2'b01 yellow, 2'b10 green
cr_light  output  2  CR lamp, same encoding
state  output  3  current state code, for debug
phase_chg  output  1  one-cycle pulse in the first cycle of every new state

Behaviour:
- States and codes:
  - HW_GREEN=0, HW_YELLOW=1, ALLRED_A=2, CR_GREEN=3, CR_YELLOW=4, ALLRED_B=5.
  - Codes 6 and 7 are illegal and go to HW_GREEN on the next clk.
- Reset values:
  - state=HW_GREEN, timer=0, req=0, phase_chg=0.
  - hw_light=10, cr_light=00.
- Outputs are registered and decoded from state, so lamps change in the same cycle state changes.
  - HW_GREEN: hw=10, cr=00.
  - HW_YELLOW: hw=01, cr=00.
  - ALLRED_A and ALLRED_B: hw=00, cr=00.
  - CR_GREEN: hw=00, cr=10.
  - CR_YELLOW: hw=00, cr=01.
- Timer:
  - Cleared to 0 on every state change.
  - Otherwise increments on tick and saturates at 2^CNT_W-1.
  - "expire(T)" means tick=1 and timer==T-1, so a state lasts exactly T ticks.
- req:
  - Set on any cycle with sensor=1 while in HW_GREEN, HW_YELLOW, ALLRED_A or ALLRED_B.
  - Cleared on entry to CR_GREEN.
- Transitions:
  - HW_GREEN -> HW_YELLOW: tick=1 and timer>=GREEN_MIN-1 and (req or sensor). Otherwise HW_GREEN holds indefinitely.
  - HW_YELLOW -> ALLRED_A: on expire(YELLOW_T).
  - ALLRED_A -> CR_GREEN: on expire(ALLRED_T).
  - CR_GREEN -> CR_YELLOW: tick=1 and either (timer>=GREEN_MIN-1 and sensor=0) or timer==GREEN_MAX-1.
  - CR_YELLOW -> ALLRED_B: on expire(YELLOW_T).
  - ALLRED_B -> HW_GREEN: on expire(ALLRED_T).
- Boundary conditions:
  - Sensor set in the same cycle req clears (CR_GREEN entry) does not re-set req. Presence is then handled by the CR_GREEN sensor term.
  - A sensor pulse shorter than GREEN_MIN during HW_GREEN is remembered via req.
  - With GREEN_MIN==GREEN_MAX, CR green is fixed length.
  - tick=0 freezes the timer and state, except reset and illegal-state recovery.
  - Reset mid-phase forces HW_GREEN immediately (asynchronous) and suppresses phase_chg.
- phase_chg is registered (state != previous state) and is 0 in the first cycle after reset release.

Optional Feature:
PED_CROSS_EN
- When defined, adds:
  - Input ped_req (1): pedestrian button, synchronous.
  - Output walk (1): registered walk lamp.
- ped_req behaves as an additional request source:
  - Sets req in the same states as sensor.
  - Latched separately as ped_lat, cleared on CR_GREEN entry.
- walk=1 throughout CR_GREEN entered while ped_lat was set.
- While walk=1, CR_GREEN lasts at least GREEN_MAX ticks regardless of sensor.
- walk resets to 0.
- When undefined: no ped_req or walk ports, and behaviour is exactly as above.

Test Plan:
- Defaults, tick=1, sensor=0 for 40 cycles after reset -> state=0, hw=10, cr=00 throughout, phase_chg never asserts.
- tick=1, sensor=1 held from reset release (cycle 0) -> states:
  - HW_GREEN cycles 0-3, HW_YELLOW 4-5, ALLRED_A 6, CR_GREEN 7-14 (GREEN_MAX cap), CR_YELLOW 15-16, ALLRED_B 17, HW_GREEN 18.
  - phase_chg high on cycles 4,6,7,15,17,18.
- tick=1, sensor pulsed 1 cycle at cycle 1 -> req latched; HW_YELLOW at cycle 4; CR_GREEN at 7-10 (GREEN_MIN, sensor low); CR_YELLOW at 11.
- tick every 3rd clk, sensor=1 -> every state duration is 3x the tick counts above; state holds between ticks.
- Reset asserted at cycle 9 (in CR_GREEN) -> state=0, hw=10, cr=00 asynchronously; after release, timer restarts at 0 and no phase_chg pulse occurs.
- PED_CROSS_EN, sensor=0, ped_req pulse at cycle 2 -> CR_GREEN cycles 7-14 with walk=1 for those 8 cycles; walk=0 elsewhere.
